// File: rtl/edge_detection.sv
// ============================================================================
// Module   : edge_detection
// Brief    : Horizontal central-difference edge detector on a pixel stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detection #(
    parameter int DATA_W    = 8,
    parameter int THRESHOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic [DATA_W-1:0] In_Arrary,
    output logic [DATA_W-1:0] Edges
);

    localparam logic [DATA_W:0] C_THRESHOLD = THRESHOLD[DATA_W:0];
    localparam logic [1:0]      C_FILL_FULL = 2'd2;

    logic [DATA_W-1:0] r_w1;
    logic [DATA_W-1:0] r_w2;
    logic [1:0]        r_fill;
    logic [DATA_W-1:0] r_edges;

    logic [DATA_W:0]   w_grad;
    logic [DATA_W:0]   w_grad_neg;
    logic [DATA_W-1:0] w_mag;
    logic              w_is_edge;

    // Zero-extend both operands so the difference is exact in DATA_W+1 bits.
    assign w_grad     = {1'b0, In_Arrary} - {1'b0, r_w2};
    assign w_grad_neg = -w_grad;
    assign w_mag      = w_grad[DATA_W] ? w_grad_neg[DATA_W-1:0] : w_grad[DATA_W-1:0];
    assign w_is_edge  = ({1'b0, w_mag} >= C_THRESHOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w1    <= '0;
            r_w2    <= '0;
            r_fill  <= 2'd0;
            r_edges <= '0;
        end else if (enb) begin
            r_w2 <= r_w1;
            r_w1 <= In_Arrary;
            if (r_fill != C_FILL_FULL) begin
                r_fill <= r_fill + 2'd1;
            end
            if (r_fill == C_FILL_FULL && w_is_edge) begin
                r_edges <= w_mag;
            end else begin
                r_edges <= '0;
            end
        end
    end

    assign Edges = r_edges;

endmodule

`default_nettype wire

// File: tb/tb_edge_detection.sv
// ============================================================================
// Module   : tb_edge_detection
// Brief    : Scoreboard bench for edge_detection with directed pixel vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_detection;

    localparam int DATA_W    = 8;
    localparam int THRESHOLD = 16;

    logic              clk;
    logic              reset;
    logic              enb;
    logic [DATA_W-1:0] In_Arrary;
    logic [DATA_W-1:0] Edges;

    int n_cmp;
    int n_err;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_exp;
    bit                stim_done;

    edge_detection #(
        .DATA_W    (DATA_W),
        .THRESHOLD (THRESHOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .In_Arrary (In_Arrary),
        .Edges     (Edges)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every enabled edge presents one result to compare against the queue;
    // idle edges must leave the previous result untouched.
    initial begin
        logic en_s;
        logic rst_s;
        forever begin
            @(posedge clk);
            en_s  = enb;
            rst_s = reset;
            #1;
            if (rst_s && en_s) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL underflow: output with empty scoreboard at %0t", $time);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("edges", Edges, last_exp);
                end
            end else if (rst_s) begin
                check("hold", Edges, last_exp);
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] pix, input logic [DATA_W-1:0] exp);
        @(negedge clk);
        reset     = 1'b1;
        enb       = 1'b1;
        In_Arrary = pix;
        exp_q.push_back(exp);
    endtask

    task automatic idle(input int n, input logic [DATA_W-1:0] pix);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset     = 1'b1;
            enb       = 1'b0;
            In_Arrary = pix;
        end
    endtask

    // Asserts reset between clock edges; the following send() releases it so the
    // very next edge must already capture a sample.
    task automatic do_reset;
        @(negedge clk);
        enb = 1'b1;
        #2;
        reset    = 1'b0;
        last_exp = '0;
        #1;
        check("async_reset", Edges, '0);
    endtask

    task automatic run_vec(input logic [DATA_W-1:0] pix[], input logic [DATA_W-1:0] exp[]);
        do_reset();
        for (int i = 0; i < pix.size(); i++) send(pix[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0d expected done", stim_done);
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        last_exp  = '0;
        stim_done = 1'b0;
        reset     = 1'b0;
        enb       = 1'b0;
        In_Arrary = '0;

        #12;
        check("reset_state", Edges, '0);
        #1;
        reset = 1'b1;

        // Constant level never produces an edge
        run_vec('{100,100,100,100,100,100,100,100}, '{0,0,0,0,0,0,0,0});
        // Rising step
        run_vec('{0,0,0,200,200,200,200}, '{0,0,0,200,200,0,0});
        // Falling step reported as magnitude
        run_vec('{200,200,200,50,50,50}, '{0,0,0,150,150,0});
        // Shallow ramp below threshold, then steeper ramp above it
        run_vec('{0,5,10,15,20}, '{0,0,0,0,0});
        run_vec('{0,10,20,30}, '{0,0,20,20});
        // Threshold boundary: 15 rejected, 16 accepted
        run_vec('{0,0,15,16}, '{0,0,0,16});
        // Full-scale swing in both directions
        run_vec('{255,0,0,255}, '{0,0,255,255});

        // Enable gating holds history and output
        run_vec('{0,0,0,200}, '{0,0,0,200});
        idle(3, 8'd0);
        send(200, 200);

        // Mid-row reset discards history: first two samples after release give 0
        run_vec('{0,0,0}, '{0,0,0});
        do_reset();
        send(200, 0);
        send(200, 0);
        send(200, 0);

        // Rows of 150 pixels separated by reset pulses
        for (int row = 0; row < 3; row++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                send((i < 10) ? 8'd0 : 8'd255, (i == 10 || i == 11) ? 8'd255 : 8'd0);
            end
        end

        idle(3, 8'd0);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/edge_detection.md
EDGE_DETECTION -- requirements
Module: edge_detection

Interface
REQ-001 Parameter DATA_W, default 8, pixel and edge-magnitude width in bits.
REQ-002 Parameter THRESHOLD, default 16, minimum gradient magnitude reported as an edge; smaller magnitudes are forced to 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 enb  input  1  sample enable; when 1, In_Arrary is consumed on the rising edge.
REQ-006 In_Arrary  input  DATA_W  unsigned pixel stream, one pixel per enabled cycle, scanned along one row.
REQ-007 Edges  output  DATA_W  registered unsigned one-direction (horizontal) gradient magnitude.

Function
REQ-008 Block SHALL hold a 2-deep pixel history (w1 = previous sample, w2 = sample before that) plus a fill counter saturating at 2.
REQ-009 On a rising clk with enb=1 and reset deasserted, block SHALL shift w2<=w1, w1<=In_Arrary, and increment fill (saturating at 2).
REQ-010 Gradient SHALL be the central difference g = In_Arrary - w2 (current minus two-back, kernel [-1 0 +1]), computed at DATA_W+1 bits signed; magnitude |g| fits DATA_W bits without saturation.
REQ-011 On an enabled edge with fill=2 (before increment), Edges SHALL load |g| if |g| >= THRESHOLD, else 0.
REQ-012 On an enabled edge with fill<2, Edges SHALL load 0 (window not yet full).
REQ-013 Latency: Edges reflects the pixel sampled on edge N immediately after edge N (one register stage); no combinational path from In_Arrary to Edges.
REQ-014 With enb=0, history, fill counter and Edges SHALL hold their values.
REQ-015 Output is magnitude only; rising and falling edges are indistinguishable.
REQ-016 No row-length knowledge inside the block; row boundaries are handled by the controller pulsing reset between rows.

Reset
REQ-017 While reset=0, w1, w2, fill and Edges SHALL be 0, asynchronously, regardless of clk and enb.
REQ-018 Reset asserted mid-row SHALL discard history; the first two enabled samples after release produce Edges=0.
REQ-019 Release of reset SHALL take effect at the next rising edge; no sample is lost if enb=1 on that edge.

Verification
REQ-020 Reset then stream constant 100 with enb=1 -> Edges 0 on every cycle.
REQ-021 Stream 0,0,0,200,200,200,200 -> Edges 0,0,0,200,200,0,0.
REQ-022 Stream 200,200,200,50,50,50 -> Edges 0,0,0,150,150,0 (falling step reported as magnitude).
REQ-023 Ramp 0,5,10,15,20 (|g|=10 < THRESHOLD 16) -> Edges all 0; ramp 0,10,20,30 (|g|=20) -> Edges 0,0,20,20.
REQ-024 Stream 0,0,0,200 then enb=0 for 3 cycles with In_Arrary=0 -> Edges holds 200; on resuming with 200 -> Edges 200.
REQ-025 150-pixel row, reset pulsed low between rows (row pattern 0 x10, 255 x140) -> first two outputs of each row 0, Edges=255 at pixels 10 and 11, 0 elsewhere; identical on every row.
